// File: rtl/addsub_bcd_calc.sv
// addsub_bcd_calc: signed add/subtract calculator with accumulate mode.
// A button press captures the operands and computes the result. The result's
// magnitude is then converted to BCD one bit per clock (double-dabble). The
// BCD value drives active-low 7-segment digits with leading-zero blanking,
// plus sign and overflow LEDs.
// Optional feature macro: SATURATE_EN. When it is defined, an overflowed result
// clamps to the signed limit instead of wrapping.
module addsub_bcd_calc #(
    parameter int W      = 6,
    parameter int DIGITS = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [W-1:0]          A,
    input  logic [W-1:0]          B,
    input  logic                  Add_Sub,
    input  logic                  Accum,
    input  logic                  button,
    output logic [7*DIGITS-1:0]   hex_Answer,
    output logic                  answer_LED,
    output logic                  OF_LED,
    output logic                  busy,
    output logic                  done
);

    localparam int BW = 4 * DIGITS;   // BCD field width
    localparam int SW = BW + W;       // double-dabble shift register width

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        CONVERT = 2'd2,
        UPDATE  = 2'd3
    } state_t;

    state_t          state_reg, state_next;
    logic            sync1_reg, sync2_reg, sync3_reg;
    logic            press;
    logic [W-1:0]    acc_reg;
    logic            sign_reg;
    logic            of_reg;
    logic [SW-1:0]   shift_reg;
    logic [W-1:0]    cnt_reg;

    logic [W-1:0]    op_a;
    logic [W-1:0]    sum_raw;
    logic            ovf;
    logic [W-1:0]    res;
    logic [W-1:0]    mag;

    logic [BW-1:0]   bcd_cur;
    logic [BW-1:0]   bcd_adj;
    logic [SW-1:0]   dd_shifted;
    logic [DIGITS-1:0]   digit_nz;
    logic [7*DIGITS-1:0] seg_next;

    // Active-low segment pattern for one decimal digit; a non-BCD code is blank.
    function automatic logic [6:0] seg_code(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    // The sync chain idles high (button released).
    // A press is the falling edge seen between the 2nd and 3rd flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_reg <= 1'b1;
            sync2_reg <= 1'b1;
            sync3_reg <= 1'b1;
        end else begin
            sync1_reg <= button;
            sync2_reg <= sync1_reg;
            sync3_reg <= sync2_reg;
        end
    end

    assign press = ~sync2_reg & sync3_reg;
    assign busy  = (state_reg != IDLE);

    // Register the FSM state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    // Next-state logic. A press is accepted only while sitting in IDLE.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (press) state_next = CAPTURE;
            CAPTURE: state_next = CONVERT;
            CONVERT: if (cnt_reg == W'(1)) state_next = UPDATE;
            UPDATE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Arithmetic: operand select, add/sub with wrap, signed overflow, magnitude.
    always_comb begin
        op_a    = Accum ? acc_reg : A;
        sum_raw = Add_Sub ? (op_a - B) : (op_a + B);
        if (Add_Sub)
            ovf = (op_a[W-1] != B[W-1]) && (sum_raw[W-1] != op_a[W-1]);
        else
            ovf = (op_a[W-1] == B[W-1]) && (sum_raw[W-1] != op_a[W-1]);
`ifdef SATURATE_EN
        // Overflow direction always follows the sign of operand A.
        if (ovf)
            res = op_a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        else
            res = sum_raw;
`else
        res = sum_raw;
`endif
        // -2^(W-1) negates to itself, which reads correctly as unsigned 2^(W-1).
        mag = res[W-1] ? (~res + W'(1)) : res;
    end

    assign bcd_cur = shift_reg[SW-1:W];

    // Per digit: add-3 adjustment, nonzero flag and segment decode with blanking.
    // Digit 0 is always shown. A higher digit is blanked when it and every
    // digit above it are zero.
    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_digit
            logic [3:0] d;
            assign d = bcd_cur[4*gi +: 4];
            assign bcd_adj[4*gi +: 4] = (d >= 4'd5) ? (d + 4'd3) : d;
            assign digit_nz[gi] = |d;
            if (gi == 0) begin : g_lsd
                assign seg_next[6:0] = seg_code(d);
            end else begin : g_upper
                assign seg_next[7*gi +: 7] =
                    (|digit_nz[DIGITS-1:gi]) ? seg_code(d) : 7'h7F;
            end
        end
    endgenerate

    assign dd_shifted = {bcd_adj, shift_reg[W-1:0]} << 1;

    // Datapath registers.
    // CAPTURE latches the result, sign and overflow, and loads the converter.
    // CONVERT shifts one bit per clock until the counter runs out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_reg   <= '0;
            sign_reg  <= 1'b0;
            of_reg    <= 1'b0;
            shift_reg <= '0;
            cnt_reg   <= '0;
        end else begin
            case (state_reg)
                CAPTURE: begin
                    acc_reg   <= res;
                    sign_reg  <= res[W-1];
                    of_reg    <= ovf;
                    shift_reg <= {{BW{1'b0}}, mag};
                    cnt_reg   <= W'(W);
                end
                CONVERT: begin
                    shift_reg <= dd_shifted;
                    cnt_reg   <= cnt_reg - W'(1);
                end
                default: ;
            endcase
        end
    end

    // Displays and LEDs load once per operation and hold otherwise.
    // done pulses alongside the load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hex_Answer <= {(7*DIGITS){1'b1}};
            answer_LED <= 1'b0;
            OF_LED     <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state_reg == UPDATE) begin
                hex_Answer <= seg_next;
                answer_LED <= sign_reg;
                OF_LED     <= of_reg;
                done       <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_addsub_bcd_calc.sv
// Testbench for addsub_bcd_calc (W=6, DIGITS=2).
// The reference model is integer arithmetic plus decimal digit extraction.
// The model also honours SATURATE_EN.
module tb_addsub_bcd_calc;

    localparam int W = 6;
    localparam int D = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic [W-1:0]     a, b;
    logic             add_sub, accum, button;
    logic [7*D-1:0]   hex;
    logic             led, ofl, busy, done;

    int total = 0;
    int bad   = 0;
    int acc_m = 0;

    always #5 clk = ~clk;

    addsub_bcd_calc #(.W(W), .DIGITS(D)) dut (
        .clk        (clk),
        .rst        (rst),
        .A          (a),
        .B          (b),
        .Add_Sub    (add_sub),
        .Accum      (accum),
        .button     (button),
        .hex_Answer (hex),
        .answer_LED (led),
        .OF_LED     (ofl),
        .busy       (busy),
        .done       (done)
    );

    function automatic logic [6:0] seg_of(input int dg);
        logic [6:0] t [10];
        t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
        return t[dg];
    endfunction

    function automatic logic [7*D-1:0] exp_hex(input int mag);
        logic [7*D-1:0] h;
        int p;
        p = 1;
        h = '0;
        for (int i = 0; i < D; i++) begin
            if (i > 0 && mag < p) h[7*i +: 7] = 7'h7F;
            else                  h[7*i +: 7] = seg_of((mag / p) % 10);
            p = p * 10;
        end
        return h;
    endfunction

    // Reference model: updates acc_m and returns the displayed signed result.
    task automatic model_op(input int av, input int bv, input bit sub, input bit acc_sel,
                            output int res, output bit of);
        int opa, raw, lo, hi, span;
        lo   = -(1 << (W-1));
        hi   = (1 << (W-1)) - 1;
        span = 1 << W;
        opa  = acc_sel ? acc_m : av;
        raw  = sub ? opa - bv : opa + bv;
        of   = (raw > hi) || (raw < lo);
`ifdef SATURATE_EN
        res = (raw > hi) ? hi : (raw < lo) ? lo : raw;
`else
        res = ((raw - lo + span) % span) + lo;
`endif
        acc_m = res;
    endtask

    task automatic do_reset();
        @(negedge clk);
        button = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        acc_m = 0;
        repeat (2) @(negedge clk);
    endtask

    // One full operation: press, measure latency, check displays, release.
    task automatic run_op(input int av, input int bv, input bit sub, input bit acc_sel,
                          input string name);
        int res, n, mag;
        bit of, got;
        logic [7*D-1:0] eh;
        model_op(av, bv, sub, acc_sel, res, of);
        mag = (res < 0) ? -res : res;
        eh  = exp_hex(mag);
        @(negedge clk);
        a = av[W-1:0]; b = bv[W-1:0]; add_sub = sub; accum = acc_sel;
        button = 1'b0;
        n = 0; got = 0;
        while (n < 40 && !got) begin
            @(posedge clk); #1;
            if (done) got = 1;
            else n++;
        end
        total++;
        if (!got) begin
            bad++;
            $display("FAIL %s timeout: got no done in %0d cycles, want done", name, n);
        end else if (n != W + 4) begin
            bad++;
            $display("FAIL %s latency: got %0d want %0d", name, n, W + 4);
        end
        total++;
        if (hex !== eh) begin
            bad++;
            $display("FAIL %s hex: got %h want %h (result %0d)", name, hex, eh, res);
        end
        total++;
        if (led !== (res < 0)) begin
            bad++;
            $display("FAIL %s sign: got %b want %b", name, led, (res < 0));
        end
        total++;
        if (ofl !== of) begin
            bad++;
            $display("FAIL %s overflow: got %b want %b", name, ofl, of);
        end
        @(posedge clk); #1;
        total++;
        if (done !== 1'b0) begin
            bad++;
            $display("FAIL %s done_pulse: got %b want 0", name, done);
        end
        $display("op %s: A=%0d B=%0d sub=%0b acc=%0b -> res=%0d of=%0b hex=%h",
                 name, av, bv, sub, acc_sel, res, of, hex);
        @(negedge clk);
        button = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; button = 1'b1; a = '0; b = '0; add_sub = 1'b0; accum = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (hex !== {(7*D){1'b1}}) begin bad++; $display("FAIL reset hex: got %h want %h", hex, {(7*D){1'b1}}); end
        total++; if (led !== 1'b0) begin bad++; $display("FAIL reset sign: got %b want 0", led); end
        total++; if (ofl !== 1'b0) begin bad++; $display("FAIL reset overflow: got %b want 0", ofl); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset busy: got %b want 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset done: got %b want 0", done); end
        rst = 1'b0;
        acc_m = 0;
        repeat (3) @(negedge clk);
        $display("reset: hex=%h led=%b of=%b busy=%b", hex, led, ofl, busy);
    endtask

    task automatic test_basic();
        run_op(5, 3, 1'b0, 1'b0, "add_5_3");
        total++; if (hex !== 14'h3F80) begin bad++; $display("FAIL add_5_3 literal: got %h want 3f80", hex); end
        run_op(13, 20, 1'b1, 1'b0, "sub_13_20");
        total++; if (hex !== 14'h3FF8) begin bad++; $display("FAIL sub_13_20 literal: got %h want 3ff8", hex); end
        run_op(31, 1, 1'b0, 1'b0, "ovf_31_1");
        run_op(-32, 1, 1'b1, 1'b0, "ovf_neg");
        run_op(0, 0, 1'b0, 1'b0, "zero");
    endtask

    task automatic test_accumulate();
        do_reset();
        run_op(0, 10, 1'b0, 1'b1, "acc_10");
        run_op(0, 10, 1'b0, 1'b1, "acc_20");
        run_op(0, 10, 1'b0, 1'b1, "acc_30");
        run_op(-32, 0, 1'b0, 1'b0, "min_neg");
    endtask

    task automatic test_random();
        for (int i = 0; i < 20; i++) begin
            int av, bv;
            bit sub, acs;
            av  = int'($urandom_range(0, 63)) - 32;
            bv  = int'($urandom_range(0, 63)) - 32;
            sub = 1'($urandom_range(0, 1));
            acs = ($urandom_range(0, 2) == 0);
            run_op(av, bv, sub, acs, "rand");
        end
    endtask

    // Second press during conversion must be ignored: one done, correct result.
    task automatic test_back_to_back();
        int res, n, dones;
        bit of;
        logic [7*D-1:0] eh, seen;
        model_op(9, 17, 1'b0, 1'b0, res, of);
        eh = exp_hex((res < 0) ? -res : res);
        @(negedge clk);
        a = 6'd9; b = 6'd17; add_sub = 1'b0; accum = 1'b0;
        button = 1'b0;
        dones = 0; seen = '0; n = 0;
        while (n < 10 && !busy) begin
            @(posedge clk); #1;
            if (done) begin dones++; seen = hex; end
            n++;
        end
        total++;
        if (!busy) begin bad++; $display("FAIL b2b busy: got 0 want 1"); end
        @(negedge clk); button = 1'b1;
        @(negedge clk);
        @(negedge clk); button = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (done) begin dones++; seen = hex; end
        end
        total++;
        if (dones != 1) begin bad++; $display("FAIL b2b done_count: got %0d want 1", dones); end
        total++;
        if (seen !== eh) begin bad++; $display("FAIL b2b hex: got %h want %h", seen, eh); end
        $display("op b2b: A=9 B=17 dones=%0d hex=%h", dones, seen);
        @(negedge clk); button = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    // Asynchronous reset in the middle of a conversion blanks everything.
    task automatic test_reset_mid_convert();
        int res, n;
        bit of;
        model_op(25, 2, 1'b0, 1'b0, res, of);
        @(negedge clk);
        a = 6'd25; b = 6'd2; add_sub = 1'b0; accum = 1'b0;
        button = 1'b0;
        n = 0;
        while (n < 10 && !busy) begin
            @(posedge clk); #1;
            n++;
        end
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        total++; if (hex !== {(7*D){1'b1}}) begin bad++; $display("FAIL midrst hex: got %h want %h", hex, {(7*D){1'b1}}); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst busy: got %b want 0", busy); end
        total++; if (led !== 1'b0 || ofl !== 1'b0 || done !== 1'b0) begin
            bad++; $display("FAIL midrst leds: got led=%b of=%b done=%b want 0 0 0", led, ofl, done);
        end
        $display("midrst: hex=%h busy=%b", hex, busy);
        button = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        acc_m = 0;
        repeat (4) @(negedge clk);
        run_op(0, 7, 1'b0, 1'b1, "acc_after_rst");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_accumulate();
        test_random();
        test_back_to_back();
        test_reset_mid_convert();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
